// File: rtl/vp_stream_select.sv
// Switch-selected video stream multiplexer. Board switch input is
// synchronised and debounced; the active channel only changes at the
// active stream's v_sync rising edge, or after a timeout if that stream
// has no v_sync. Pixels are blanked for BLANK_FRAMES frames after a change.

// One input channel: masks its stream onto the shared OR-bus when selected,
// and exposes its v_sync when it is the requested (next) channel.
module vp_ss_lane #(
  parameter int PX_W  = 24,
  parameter int SEL_W = 4,
  parameter int LANE  = 0
) (
  input  logic [SEL_W-1:0] sel,
  input  logic [SEL_W-1:0] nsel,
  input  logic [PX_W-1:0]  pixel,
  input  logic             de,
  input  logic             h_sync,
  input  logic             v_sync,
  output logic [PX_W-1:0]  pixel_m,
  output logic             de_m,
  output logic             h_sync_m,
  output logic             v_sync_m,
  output logic             v_sync_n
);
  logic hit, nhit;

  assign hit      = (sel  == SEL_W'(LANE));
  assign nhit     = (nsel == SEL_W'(LANE));
  assign pixel_m  = hit ? pixel : '0;
  assign de_m     = hit & de;
  assign h_sync_m = hit & h_sync;
  assign v_sync_m = hit & v_sync;
  assign v_sync_n = nhit & v_sync;
endmodule

module vp_stream_select #(
  parameter int NUM_CH       = 16,
  parameter int SEL_W        = 4,
  parameter int PX_W         = 24,
  parameter int DEFAULT_SEL  = 0,
  parameter int DEBOUNCE_CYC = 1024,
  parameter int BLANK_FRAMES = 1,
  parameter int TIMEOUT_CYC  = 1 << 22
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CH*PX_W-1:0] pixel_in,
  input  logic [NUM_CH-1:0]      de_in,
  input  logic [NUM_CH-1:0]      h_sync_in,
  input  logic [NUM_CH-1:0]      v_sync_in,
  input  logic [SEL_W-1:0]       sw,
  output logic                   de_out,
  output logic                   h_sync_out,
  output logic                   v_sync_out,
  output logic [PX_W-1:0]        pixel_out,
  output logic [SEL_W-1:0]       active_sel,
  output logic                   pending,
  output logic                   blanking
);
  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int FR_W = (BLANK_FRAMES > 1) ? $clog2(BLANK_FRAMES) : 1;
  localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DEBOUNCE_CYC);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [FR_W-1:0] FR_LAST = FR_W'((BLANK_FRAMES > 0) ? BLANK_FRAMES - 1 : 0);

  typedef enum logic [1:0] {IDLE, WAIT_VS, BLANK} state_t;

  // switch sync / debounce
  logic [SEL_W-1:0] sw_meta, sw_sync, sw_cand, sw_stable;
  logic [DB_W-1:0]  db_cnt, db_cnt_d;
  logic             db_done, acc, in_range, req_ok, cancel;

  // control
  state_t           state_q, state_d;
  logic [SEL_W-1:0] req_sel, req_d, act_d;
  logic             pend_d, do_switch;
  logic [TO_W-1:0]  to_cnt, to_d;
  logic [FR_W-1:0]  fr_cnt, fr_d;
  logic             vs_prev, vs_cur, vs_new, vs_rise;

  // lane bus
  logic [NUM_CH-1:0][PX_W-1:0] lane_px;
  logic [NUM_CH-1:0]           lane_de, lane_hs, lane_vs, lane_vn;
  logic [PX_W-1:0]             mux_px;
  logic                        mux_de, mux_hs;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    vp_ss_lane #(.PX_W(PX_W), .SEL_W(SEL_W), .LANE(g)) u_lane (
      .sel      (active_sel),
      .nsel     (req_sel),
      .pixel    (pixel_in[g*PX_W +: PX_W]),
      .de       (de_in[g]),
      .h_sync   (h_sync_in[g]),
      .v_sync   (v_sync_in[g]),
      .pixel_m  (lane_px[g]),
      .de_m     (lane_de[g]),
      .h_sync_m (lane_hs[g]),
      .v_sync_m (lane_vs[g]),
      .v_sync_n (lane_vn[g])
    );
  end

  // OR-reduce the one-hot masked lanes into the selected stream
  always_comb begin
    mux_px = '0;
    for (int i = 0; i < NUM_CH; i++) mux_px = mux_px | lane_px[i];
  end

  assign mux_de  = |lane_de;
  assign mux_hs  = |lane_hs;
  assign vs_cur  = |lane_vs;
  assign vs_new  = |lane_vn;
  assign vs_rise = vs_cur & ~vs_prev;

  // debounce: count consecutive equal samples, restart on any change
  always_comb begin
    db_cnt_d = db_cnt;
    db_done  = 1'b0;
    if (sw_sync != sw_cand) begin
      db_cnt_d = DB_W'(1);
      db_done  = (DEBOUNCE_CYC == 1);
    end else if (db_cnt < DB_MAX) begin
      db_cnt_d = db_cnt + DB_W'(1);
      db_done  = (db_cnt_d == DB_MAX);
    end
  end

  // a settled value that differs from the last accepted one is an accept event
  assign acc      = db_done && (sw_sync != sw_stable);
  assign in_range = acc && (int'(sw_sync) < NUM_CH);
  assign req_ok   = in_range && (sw_sync != active_sel);
  assign cancel   = in_range && (sw_sync == active_sel);

  // synchroniser, debounce and accepted-value registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_meta   <= '0;
      sw_sync   <= '0;
      sw_cand   <= '0;
      db_cnt    <= '0;
      sw_stable <= SEL_W'(DEFAULT_SEL);
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
      sw_cand <= sw_sync;
      db_cnt  <= db_cnt_d;
      if (acc) sw_stable <= sw_sync;
    end
  end

  // next-state: request latch, frame-boundary switch, timeout, blank count
  always_comb begin
    state_d   = state_q;
    req_d     = req_sel;
    pend_d    = pending;
    act_d     = active_sel;
    to_d      = '0;
    fr_d      = fr_cnt;
    do_switch = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_ok) begin
          req_d   = sw_sync;
          pend_d  = 1'b1;
          state_d = WAIT_VS;
        end
      end
      WAIT_VS: begin
        to_d = to_cnt + TO_W'(1);
        if (vs_rise || to_cnt == TO_LAST) begin
          do_switch = 1'b1;
          act_d     = req_sel;
          pend_d    = 1'b0;
          to_d      = '0;
          fr_d      = '0;
          state_d   = (BLANK_FRAMES > 0) ? BLANK : IDLE;
          // a request landing on the switch cycle queues behind this switch
          if (in_range && sw_sync != req_sel) begin
            req_d  = sw_sync;
            pend_d = 1'b1;
            if (BLANK_FRAMES == 0) state_d = WAIT_VS;
          end
        end else if (req_ok) begin
          req_d = sw_sync;
        end else if (cancel) begin
          pend_d  = 1'b0;
          state_d = IDLE;
        end
      end
      BLANK: begin
        if (req_ok) begin
          req_d  = sw_sync;
          pend_d = 1'b1;
        end else if (cancel) begin
          pend_d = 1'b0;
        end
        if (vs_rise) begin
          if (fr_cnt == FR_LAST) begin
            fr_d    = '0;
            state_d = pend_d ? WAIT_VS : IDLE;
          end else begin
            fr_d = fr_cnt + FR_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // control registers; vs_prev tracks the new channel on the switch cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      req_sel    <= SEL_W'(DEFAULT_SEL);
      pending    <= 1'b0;
      active_sel <= SEL_W'(DEFAULT_SEL);
      to_cnt     <= '0;
      fr_cnt     <= '0;
      vs_prev    <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_sel    <= req_d;
      pending    <= pend_d;
      active_sel <= act_d;
      to_cnt     <= to_d;
      fr_cnt     <= fr_d;
      vs_prev    <= do_switch ? vs_new : vs_cur;
    end
  end

  // registered output stage; pixel forced black while blanking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de_out     <= 1'b0;
      h_sync_out <= 1'b0;
      v_sync_out <= 1'b0;
      pixel_out  <= '0;
    end else begin
      de_out     <= mux_de;
      h_sync_out <= mux_hs;
      v_sync_out <= vs_cur;
      pixel_out  <= (state_q == BLANK) ? '0 : mux_px;
    end
  end

  assign blanking = (state_q == BLANK);

endmodule

// File: tb/tb_vp_stream_select.sv
// Directed bench for vp_stream_select: stimulus pushes expected pixels into a
// queue, a forked monitor pops and compares on every de_out cycle; control
// outputs are checked directly at hand-computed cycles.
module tb_vp_stream_select;
  localparam int NUM_CH = 8;
  localparam int SEL_W  = 4;
  localparam int PX_W   = 24;

  logic                   clk, rst;
  logic [NUM_CH*PX_W-1:0] pixel_in;
  logic [NUM_CH-1:0]      de_in, h_sync_in, v_sync_in;
  logic [SEL_W-1:0]       sw;
  logic                   de_out, h_sync_out, v_sync_out;
  logic [PX_W-1:0]        pixel_out;
  logic [SEL_W-1:0]       active_sel;
  logic                   pending, blanking;

  int          checks = 0;
  int          errors = 0;
  logic [23:0] q[$];
  int          exp_ch;
  logic        exp_blk;

  vp_stream_select #(
    .NUM_CH(NUM_CH), .SEL_W(SEL_W), .PX_W(PX_W), .DEFAULT_SEL(2),
    .DEBOUNCE_CYC(4), .BLANK_FRAMES(1), .TIMEOUT_CYC(100)
  ) dut (
    .clk(clk), .rst(rst), .pixel_in(pixel_in), .de_in(de_in),
    .h_sync_in(h_sync_in), .v_sync_in(v_sync_in), .sw(sw),
    .de_out(de_out), .h_sync_out(h_sync_out), .v_sync_out(v_sync_out),
    .pixel_out(pixel_out), .active_sel(active_sel), .pending(pending),
    .blanking(blanking)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // one clock of stimulus; expected pixel reflects the channel/blank state of this cycle
  task automatic cyc(input logic de, input logic [7:0] vs);
    de_in     = {NUM_CH{de}};
    h_sync_in = {NUM_CH{~de}};
    v_sync_in = vs;
    if (de) q.push_back(exp_blk ? 24'h0 : 24'(exp_ch) * 24'h010101);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input logic de);
    repeat (n) cyc(de, 8'h00);
  endtask

  task automatic monitor();
    logic [23:0] e;
    forever begin
      @(negedge clk);
      if (!rst && de_out) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard: de_out with no expected pixel, got %0h", pixel_out);
        end else begin
          e = q.pop_front();
          check("pixel_out", 32'(pixel_out), 32'(e));
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NUM_CH; i++) pixel_in[i*PX_W +: PX_W] = 24'(i) * 24'h010101;
    de_in = '0; h_sync_in = '0; v_sync_in = '0;
    sw = 4'd2; exp_ch = 2; exp_blk = 1'b0;
    rst = 1'b0;
    fork
      monitor();
    join_none
    #3 rst = 1'b1;

    // 1: reset state, default channel
    repeat (3) @(posedge clk);
    #1;
    check("rst_active_sel", 32'(active_sel), 32'd2);
    check("rst_pixel_out", 32'(pixel_out), 32'd0);
    check("rst_de_out", 32'(de_out), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_blanking", 32'(blanking), 32'd0);
    rst = 1'b0;
    run(10, 1'b1);
    check("t1_active_sel", 32'(active_sel), 32'd2);

    // 2: request ch5 mid-frame, switch on ch2 v_sync, one blanked frame
    sw = 4'd5;
    run(5, 1'b1);
    check("t2_pending_early", 32'(pending), 32'd0);
    run(1, 1'b1);
    check("t2_pending_rise", 32'(pending), 32'd1);
    cyc(1'b1, 8'h20);                 // v_sync of the requested channel is ignored
    check("t2_no_switch_ch5_vs", 32'(active_sel), 32'd2);
    run(3, 1'b1);
    cyc(1'b0, 8'h04);                 // ch2 v_sync rises: switch
    check("t2_active_sel", 32'(active_sel), 32'd5);
    check("t2_blanking", 32'(blanking), 32'd1);
    check("t2_pending_clr", 32'(pending), 32'd0);
    check("t2_old_vs_out", 32'(v_sync_out), 32'd1);
    exp_ch = 5; exp_blk = 1'b1;
    run(6, 1'b1);
    cyc(1'b0, 8'h20);                 // ch5 frame boundary ends blanking
    check("t2_blank_end", 32'(blanking), 32'd0);
    check("t2_vs_passthru", 32'(v_sync_out), 32'd1);
    exp_blk = 1'b0;
    run(4, 1'b1);

    // 5: no v_sync on ch5, request ch1, forced switch after exactly 100 cycles
    sw = 4'd1;
    run(6, 1'b1);
    check("t5_pending", 32'(pending), 32'd1);
    run(99, 1'b1);
    check("t5_not_yet", 32'(active_sel), 32'd5);
    run(1, 1'b1);
    check("t5_timeout_sel", 32'(active_sel), 32'd1);
    check("t5_blanking", 32'(blanking), 32'd1);
    exp_ch = 1; exp_blk = 1'b1;
    run(3, 1'b1);
    cyc(1'b0, 8'h02);
    exp_blk = 1'b0;
    run(3, 1'b1);

    // move to ch3 so the bounce test starts from a settled 3
    sw = 4'd3;
    run(8, 1'b1);
    cyc(1'b0, 8'h02);
    check("to3_active_sel", 32'(active_sel), 32'd3);
    exp_ch = 3; exp_blk = 1'b1;
    run(3, 1'b1);
    cyc(1'b0, 8'h08);
    exp_blk = 1'b0;
    run(3, 1'b1);

    // 3: bounce 3->7->3 never produces a request
    sw = 4'd7;
    run(1, 1'b1);
    sw = 4'd3;
    for (int i = 0; i < 12; i++) begin
      run(1, 1'b1);
      check("t3_no_pending", 32'(pending), 32'd0);
    end
    check("t3_active_sel", 32'(active_sel), 32'd3);

    // 4: out-of-range request is ignored
    sw = 4'd14;
    run(12, 1'b1);
    check("t4_pending", 32'(pending), 32'd0);
    check("t4_active_sel", 32'(active_sel), 32'd3);

    // 6: switch to ch6, request ch4 during BLANK
    sw = 4'd6;
    run(8, 1'b1);
    cyc(1'b0, 8'h08);
    check("t6_sel6", 32'(active_sel), 32'd6);
    exp_ch = 6; exp_blk = 1'b1;
    sw = 4'd4;
    run(5, 1'b1);
    check("t6_pending_early", 32'(pending), 32'd0);
    run(1, 1'b1);
    check("t6_pending_blank", 32'(pending), 32'd1);
    check("t6_still_blank", 32'(blanking), 32'd1);
    run(2, 1'b1);
    cyc(1'b0, 8'h40);
    check("t6_blank_exit", 32'(blanking), 32'd0);
    check("t6_pending_kept", 32'(pending), 32'd1);
    check("t6_sel_kept", 32'(active_sel), 32'd6);
    exp_blk = 1'b0;
    run(4, 1'b1);
    cyc(1'b0, 8'h40);
    check("t6_sel4", 32'(active_sel), 32'd4);
    check("t6_blank4", 32'(blanking), 32'd1);
    check("t6_pending_done", 32'(pending), 32'd0);

    // 6b: asynchronous reset mid-BLANK with a request pending
    exp_ch = 4; exp_blk = 1'b1;
    sw = 4'd1;
    run(6, 1'b1);
    check("t6r_pending_pre", 32'(pending), 32'd1);
    check("t6r_de_pre", 32'(de_out), 32'd1);
    de_in = '0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6r_de_out", 32'(de_out), 32'd0);
    check("t6r_pixel_out", 32'(pixel_out), 32'd0);
    check("t6r_active_sel", 32'(active_sel), 32'd2);
    check("t6r_pending", 32'(pending), 32'd0);
    check("t6r_blanking", 32'(blanking), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    exp_ch = 2; exp_blk = 1'b0;
    run(3, 1'b1);
    run(2, 1'b0);
    check("sb_drained", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
